uart_rx_frame_ctrl: RTL and testbench



---
 rtl/uart_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frames UART bytes (SYNC ADDR LEN payload CHK) into register writes.
// Optional `FRAME_ERR_CNT_EN adds a saturating err_cnt output.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 21700
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
`ifdef FRAME_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW =
    (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    HUNT, ADDR, LEN, PAYLOAD, CHK, DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    base_q, base_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    pbuf [MAX_LEN];
  logic          buf_we;
  logic          wr_valid_d;
  logic [7:0]    wr_addr_d, wr_data_d;
  logic          ok_d, err_d;
  logic [1:0]    code_d;
  logic          in_frame, tmo, last;
  logic [7:0]    nidx;

  assign in_frame = (state_q == ADDR) || (state_q == LEN) ||
                    (state_q == PAYLOAD) || (state_q == CHK);
  assign tmo  = (tcnt_q == T_LAST);
  assign last = (idx_q == len_q - 8'd1);
  assign nidx = idx_q + 8'd1;
  assign busy = (state_q != HUNT);

  // a byte on the terminal-count cycle clears the counter instead
  assign tcnt_d = (in_frame && !rx_valid && !tmo)
                ? tcnt_q + TW'(1) : '0;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    buf_we     = 1'b0;
    wr_valid_d = wr_valid;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = err_code;
    unique case (state_q)
      HUNT: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ADDR;
          chk_d   = '0;
        end
      end
      ADDR: begin
        if (rx_valid) begin
          base_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = LEN;
        end else if (tmo) begin
          err_d = 1'b1; code_d = 2'd2; state_d = HUNT;
        end
      end
      LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > LEN_MAX) begin
            err_d = 1'b1; code_d = 2'd0; state_d = HUNT;
          end else begin
            len_d   = rx_data;
            chk_d   = chk_q ^ rx_data;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end else if (tmo) begin
          err_d = 1'b1; code_d = 2'd2; state_d = HUNT;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_data;
          idx_d  = nidx;
          if (last) state_d = CHK;
        end else if (tmo) begin
          err_d = 1'b1; code_d = 2'd2; state_d = HUNT;
        end
      end
      CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            ok_d       = 1'b1;
            idx_d      = '0;
            wr_valid_d = 1'b1;
            wr_addr_d  = base_q;
            wr_data_d  = pbuf[0];
            state_d    = DRAIN;
          end else begin
            err_d = 1'b1; code_d = 2'd1; state_d = HUNT;
          end
        end else if (tmo) begin
          err_d = 1'b1; code_d = 2'd2; state_d = HUNT;
        end
      end
      DRAIN: begin
        if (rx_valid) begin
          err_d = 1'b1; code_d = 2'd3;
        end
        if (wr_valid && wr_ready) begin
          if (last) begin
            wr_valid_d = 1'b0;
            idx_d      = '0;
            state_d    = HUNT;
          end else begin
            idx_d     = nidx;
            wr_addr_d = base_q + nidx;
            wr_data_d = pbuf[nidx[IW-1:0]];
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      tcnt_q    <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      tcnt_q    <= tcnt_d;
      wr_valid  <= wr_valid_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      err_code  <= code_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) pbuf[i] <= '0;
    end else if (buf_we) begin
      pbuf[idx_q[IW-1:0]] <= rx_data;
    end
  end

`ifdef FRAME_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_d && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level reference model,
// directed frames with literal expectations, then random traffic.
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAX = 8;
  localparam int TO  = 21700;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
`ifdef FRAME_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  uart_rx_frame_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code),
`ifdef FRAME_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // frame-level reference model
  bit         m_in;
  logic [7:0] fb [$];
  logic [15:0] wq [$];
  int         gap;
  bit         e_ok, e_err;
  logic [1:0] e_code;
  int         e_cnt;
  logic [7:0] mx;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_in = 0; fb.delete(); wq.delete(); gap = 0;
      e_ok = 0; e_err = 0; e_code = 0; e_cnt = 0;
    end else begin
      e_ok = 0; e_err = 0;
      if (wq.size() > 0) begin
        if (rx_valid) begin e_err = 1; e_code = 2'd3; end
        if (wr_ready) void'(wq.pop_front());
      end else if (!m_in) begin
        if (rx_valid && rx_data == SYNC) begin
          m_in = 1; fb.delete(); gap = 0;
        end
      end else if (rx_valid) begin
        gap = 0;
        fb.push_back(rx_data);
        if (fb.size() == 2 && (fb[1] == 0 || fb[1] > MAX)) begin
          e_err = 1; e_code = 2'd0; m_in = 0;
        end else if (fb.size() >= 3 &&
                     fb.size() == int'(fb[1]) + 3) begin
          mx = 0;
          for (int i = 0; i < fb.size() - 1; i++) mx ^= fb[i];
          if (mx == fb[fb.size()-1]) begin
            e_ok = 1;
            for (int i = 0; i < int'(fb[1]); i++)
              wq.push_back({8'(fb[0] + 8'(i)), fb[i+2]});
          end else begin
            e_err = 1; e_code = 2'd1;
          end
          m_in = 0;
        end
      end else begin
        gap++;
        if (gap == TO) begin e_err = 1; e_code = 2'd2; m_in = 0; end
      end
      if (e_err && e_cnt < 255) e_cnt++;
    end
  end

  // compare process plus DUT event logging
  int ok_n = 0, err_n = 0, err_cyc = 0;
  logic [1:0] last_code = 0;
  logic [7:0] wl_a [$];
  logic [7:0] wl_d [$];
  int         wl_c [$];

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      check("wr_valid", 32'(wr_valid), 32'(wq.size() > 0));
      if (wr_valid && wq.size() > 0) begin
        check("wr_addr", 32'(wr_addr), 32'(wq[0][15:8]));
        check("wr_data", 32'(wr_data), 32'(wq[0][7:0]));
      end
      check("frame_ok", 32'(frame_ok), 32'(e_ok));
      check("frame_err", 32'(frame_err), 32'(e_err));
      if (e_err) check("err_code", 32'(err_code), 32'(e_code));
      check("busy", 32'(busy), 32'(m_in || wq.size() > 0));
`ifdef FRAME_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt), 32'(e_cnt));
`endif
      if (frame_ok) ok_n++;
      if (frame_err) begin
        err_n++; last_code = err_code; err_cyc = cyc;
      end
      if (wr_valid && wr_ready) begin
        wl_a.push_back(wr_addr);
        wl_d.push_back(wr_data);
        wl_c.push_back(cyc);
      end
    end
  end

  // 0 = manual, 1 = random, 2 = toggle
  int rmode = 0;
  initial forever begin
    @(negedge clk);
    if (rmode == 1) wr_ready = ($urandom_range(0, 3) != 0);
    else if (rmode == 2) wr_ready = !wr_ready;
  end

  task automatic set_ready(input logic v);
    rmode = 0;
    #1;
    wr_ready = v;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] fr [$];
  task automatic send_fr(input int gmax);
    foreach (fr[i]) begin
      send(fr[i]);
      idle($urandom_range(0, gmax));
    end
  endtask

  int s_ok, s_err, s_w, c0, kind, ln;
  logic [7:0] nb, ad, x;

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; wr_ready = 1'b0;
    idle(3);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_ok", 32'(frame_ok), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    rst_n = 1'b1;
    idle(2);

    // good frame, two consecutive writes
    set_ready(1'b1);
    s_ok = ok_n; s_err = err_n; s_w = wl_a.size();
    fr = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_fr(0);
    idle(5);
    check("t1_ok", 32'(ok_n - s_ok), 1);
    check("t1_err", 32'(err_n - s_err), 0);
    check("t1_nwr", 32'(wl_a.size() - s_w), 2);
    if (wl_a.size() - s_w == 2) begin
      check("t1_a0", 32'(wl_a[s_w]), 32'h10);
      check("t1_d0", 32'(wl_d[s_w]), 32'h11);
      check("t1_a1", 32'(wl_a[s_w+1]), 32'h11);
      check("t1_d1", 32'(wl_d[s_w+1]), 32'h22);
      check("t1_b2b", 32'(wl_c[s_w+1] - wl_c[s_w]), 1);
    end
    check("t1_busy", 32'(busy), 0);

    // bad CHK, then a good frame
    s_ok = ok_n; s_err = err_n; s_w = wl_a.size();
    fr = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
    send_fr(0);
    idle(3);
    check("t2_err", 32'(err_n - s_err), 1);
    check("t2_code", 32'(last_code), 1);
    check("t2_nwr", 32'(wl_a.size() - s_w), 0);
    check("t2_busy", 32'(busy), 0);
    fr = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_fr(0);
    idle(5);
    check("t2_ok", 32'(ok_n - s_ok), 1);
    check("t2_nwr2", 32'(wl_a.size() - s_w), 2);

    // bad LEN: zero and too long
    s_err = err_n; s_w = wl_a.size();
    fr = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h09};
    send_fr(0);
    idle(3);
    check("t3_err", 32'(err_n - s_err), 2);
    check("t3_code", 32'(last_code), 0);
    check("t3_nwr", 32'(wl_a.size() - s_w), 0);

    // address wrap with stalling sink
    s_ok = ok_n; s_w = wl_a.size();
    rmode = 2;
    fr = '{8'hA5, 8'hFF, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFC};
    send_fr(0);
    idle(12);
    check("t4_ok", 32'(ok_n - s_ok), 1);
    check("t4_nwr", 32'(wl_a.size() - s_w), 3);
    if (wl_a.size() - s_w == 3) begin
      check("t4_a0", 32'(wl_a[s_w]), 32'hFF);
      check("t4_d0", 32'(wl_d[s_w]), 32'h01);
      check("t4_a1", 32'(wl_a[s_w+1]), 32'h00);
      check("t4_d1", 32'(wl_d[s_w+1]), 32'h02);
      check("t4_a2", 32'(wl_a[s_w+2]), 32'h01);
      check("t4_d2", 32'(wl_d[s_w+2]), 32'h03);
    end

    // inter-byte timeout fires exactly TO cycles after last byte
    set_ready(1'b1);
    s_err = err_n;
    send(8'hA5);
    send(8'h05);
    c0 = cyc;
    idle(TO + 3);
    check("t5_err", 32'(err_n - s_err), 1);
    check("t5_code", 32'(last_code), 2);
    check("t5_when", 32'(err_cyc - c0), TO);
    check("t5_busy", 32'(busy), 0);

    // byte on the terminal-count cycle wins
    s_err = err_n; s_ok = ok_n;
    send(8'hA5);
    send(8'h05);
    idle(TO - 1);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h34);
    idle(5);
    check("t6_err", 32'(err_n - s_err), 0);
    check("t6_ok", 32'(ok_n - s_ok), 1);

    // byte during drain is dropped
    set_ready(1'b0);
    s_err = err_n; s_w = wl_a.size();
    fr = '{8'hA5, 8'h40, 8'h01, 8'h77, 8'h36};
    send_fr(0);
    idle(2);
    send(8'h33);
    idle(2);
    check("t7_err", 32'(err_n - s_err), 1);
    check("t7_code", 32'(last_code), 3);
    check("t7_stall", 32'(wr_valid), 1);
    set_ready(1'b1);
    idle(4);
    check("t7_nwr", 32'(wl_a.size() - s_w), 1);
    if (wl_a.size() - s_w == 1) begin
      check("t7_a", 32'(wl_a[s_w]), 32'h40);
      check("t7_d", 32'(wl_d[s_w]), 32'h77);
    end

    // reset in the middle of a drain
    set_ready(1'b0);
    s_w = wl_a.size();
    fr = '{8'hA5, 8'h50, 8'h02, 8'hAA, 8'hBB, 8'h43};
    send_fr(0);
    idle(2);
    #1 rst_n = 1'b0;
    #1;
    check("t8_wr_valid", 32'(wr_valid), 0);
    check("t8_busy", 32'(busy), 0);
`ifdef FRAME_ERR_CNT_EN
    check("t8_err_cnt", 32'(err_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    idle(4);
    check("t8_nwr", 32'(wl_a.size() - s_w), 0);

    // random traffic
    rmode = 1;
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      fr.delete();
      repeat ($urandom_range(0, 2)) begin
        do nb = 8'($urandom); while (nb == SYNC);
        fr.push_back(nb);
      end
      ad = 8'($urandom);
      if (kind == 0)
        ln = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(9, 255);
      else
        ln = $urandom_range(1, MAX);
      fr.push_back(SYNC);
      fr.push_back(ad);
      fr.push_back(8'(ln));
      if (kind != 0) begin
        x = ad ^ 8'(ln);
        for (int i = 0; i < ln; i++) begin
          nb = 8'($urandom);
          x ^= nb;
          fr.push_back(nb);
        end
        if (kind == 1) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
      end
      send_fr(2);
      idle($urandom_range(0, 10));
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
